blackparrot_fpga_host_mmio_arb: RTL and testbench

BLACKPARROT_FPGA_HOST_MMIO_ARB -- requirements
Module: blackparrot_fpga_host_mmio_arb

---
 rtl/blackparrot_fpga_host_mmio_arb.sv | 199 +++++++++++++++++++
 tb/tb_blackparrot_fpga_host_mmio_arb.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blackparrot_fpga_host_mmio_arb.sv
// Round-robin funnel of BP MMIO requesters onto one host FIFO pair: each request
// goes out as an address word then a data word, with one transaction in flight.

module blackparrot_fpga_host_mmio_arb_lane
  #(parameter int addr_width_p      = 64
  , parameter int fifo_data_width_p = 32
  )
  (input  logic                         sel
  ,input  logic [addr_width_p-1:0]      addr
  ,input  logic [fifo_data_width_p-1:0] data
  ,input  logic                         w
  ,input  logic                         resp_ready
  ,input  logic                         yumi_en
  ,input  logic                         resp_en
  ,output logic [2*fifo_data_width_p:0] req_masked
  ,output logic                         ready_masked
  ,output logic                         yumi
  ,output logic                         resp_v
  );

  // Only the selected lane contributes, so the top can OR all lanes together.
  assign req_masked   = sel ? {w, addr[fifo_data_width_p-1:0], data} : '0;
  assign ready_masked = sel & resp_ready;
  assign yumi         = sel & yumi_en;
  assign resp_v       = sel & resp_en;

  if (addr_width_p > fifo_data_width_p) begin : hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[addr_width_p-1:fifo_data_width_p];
  end

endmodule

module blackparrot_fpga_host_mmio_arb
  #(parameter int num_req_p         = 2
  , parameter int fifo_data_width_p = 32
  , parameter int addr_width_p      = 64
  , localparam int lg_lp            = $clog2(num_req_p)
  )
  (input  logic                                   clk
  ,input  logic                                   reset
  ,input  logic [num_req_p-1:0]                   req_v_i
  ,input  logic [num_req_p*addr_width_p-1:0]      req_addr_i
  ,input  logic [num_req_p*fifo_data_width_p-1:0] req_data_i
  ,input  logic [num_req_p-1:0]                   req_w_i
  ,output logic [num_req_p-1:0]                   req_yumi_o
  ,output logic [num_req_p-1:0]                   resp_v_o
  ,output logic [fifo_data_width_p-1:0]           resp_data_o
  ,output logic                                   resp_w_o
  ,input  logic [num_req_p-1:0]                   resp_ready_and_i
  ,output logic                                   fifo_v_o
  ,output logic [fifo_data_width_p-1:0]           fifo_data_o
  ,input  logic                                   fifo_ready_and_i
  ,input  logic                                   mmio_resp_v_i
  ,input  logic [fifo_data_width_p-1:0]           mmio_resp_data_i
  ,output logic                                   mmio_resp_yumi_o
  ,output logic [lg_lp-1:0]                       grant_id_o
  ,output logic                                   busy_o
  );

  typedef enum logic [2:0] {e_arb, e_addr, e_data, e_read_resp, e_write_resp} state_e;

  typedef struct packed {
    logic                         w;
    logic [fifo_data_width_p-1:0] addr;
    logic [fifo_data_width_p-1:0] data;
  } req_s;

  state_e           state_r, state_n;
  logic [lg_lp-1:0] grant_r, grant_n, last_r, last_n, winner;
  logic             found;
  logic [lg_lp-1:0] cand;

  logic                 yumi_en, resp_en, mmio_yumi;
  logic [num_req_p-1:0] lane_ready;
  req_s                 lane_req [num_req_p];
  logic [$bits(req_s)-1:0] sel_bits;
  req_s                 sel_req;
  logic                 sel_ready;

  for (genvar i = 0; i < num_req_p; i++) begin : lane
    blackparrot_fpga_host_mmio_arb_lane
      #(.addr_width_p(addr_width_p), .fifo_data_width_p(fifo_data_width_p))
      lane_inst
      (.sel         (grant_r == lg_lp'(i))
      ,.addr        (req_addr_i[i*addr_width_p +: addr_width_p])
      ,.data        (req_data_i[i*fifo_data_width_p +: fifo_data_width_p])
      ,.w           (req_w_i[i])
      ,.resp_ready  (resp_ready_and_i[i])
      ,.yumi_en     (yumi_en)
      ,.resp_en     (resp_en)
      ,.req_masked  (lane_req[i])
      ,.ready_masked(lane_ready[i])
      ,.yumi        (req_yumi_o[i])
      ,.resp_v      (resp_v_o[i])
      );
  end

  always_comb begin
    sel_bits = '0;
    for (int i = 0; i < num_req_p; i++) sel_bits = sel_bits | lane_req[i];
  end
  assign sel_req   = sel_bits;
  assign sel_ready = |lane_ready;

  // Rotating priority: first requester above the previous winner, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= num_req_p; k++) begin
      cand = lg_lp'((int'(last_r) + k) % num_req_p);
      if (!found && req_v_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_n     = state_r;
    grant_n     = grant_r;
    last_n      = last_r;
    fifo_v_o    = 1'b0;
    fifo_data_o = '0;
    yumi_en     = 1'b0;
    resp_en     = 1'b0;
    resp_w_o    = 1'b0;
    resp_data_o = '0;
    mmio_yumi   = 1'b0;
    unique case (state_r)
      e_arb: begin
        if (found) begin
          grant_n = winner;
          last_n  = winner;
          state_n = e_addr;
        end
      end
      e_addr: begin
        fifo_v_o    = 1'b1;
        fifo_data_o = sel_req.addr;
        if (fifo_ready_and_i) state_n = e_data;
      end
      e_data: begin
        // Reads still send the data word so the host always sees two words.
        fifo_v_o    = 1'b1;
        fifo_data_o = sel_req.data;
        yumi_en     = fifo_ready_and_i;
        if (fifo_ready_and_i) state_n = sel_req.w ? e_write_resp : e_read_resp;
      end
      e_read_resp: begin
        resp_en     = mmio_resp_v_i;
        resp_data_o = mmio_resp_data_i;
        mmio_yumi   = mmio_resp_v_i & sel_ready;
        if (mmio_yumi) state_n = e_arb;
      end
      e_write_resp: begin
        resp_en  = 1'b1;
        resp_w_o = 1'b1;
        if (sel_ready) state_n = e_arb;
      end
      default: state_n = e_arb;
    endcase
    // Outputs are quiet while reset is held, whatever state we were in.
    if (reset) begin
      fifo_v_o    = 1'b0;
      fifo_data_o = '0;
      yumi_en     = 1'b0;
      resp_en     = 1'b0;
      resp_w_o    = 1'b0;
      resp_data_o = '0;
      mmio_yumi   = 1'b0;
    end
  end

  assign mmio_resp_yumi_o = mmio_yumi;
  assign busy_o           = (state_r != e_arb) & ~reset;
  assign grant_id_o       = grant_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= e_arb;
      grant_r <= '0;
      last_r  <= lg_lp'(num_req_p-1);
    end else begin
      state_r <= state_n;
      grant_r <= grant_n;
      last_r  <= last_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(req_yumi_o));
      assert ($onehot0(resp_v_o));
    end
  end

endmodule

// File: tb/tb_blackparrot_fpga_host_mmio_arb.sv
// Random plus directed bench for blackparrot_fpga_host_mmio_arb against a
// transaction-level model of requesters, host FIFOs and round-robin order.

module tb_blackparrot_fpga_host_mmio_arb;
  localparam int N  = 3;
  localparam int AW = 64;
  localparam int LG = $clog2(N);

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_v_i, req_w_i, req_yumi_o, resp_v_o, resp_ready_and_i;
  logic [N*AW-1:0] req_addr_i;
  logic [N*32-1:0] req_data_i;
  logic [31:0]     resp_data_o, fifo_data_o, mmio_resp_data_i;
  logic            resp_w_o, fifo_v_o, fifo_ready_and_i;
  logic            mmio_resp_v_i, mmio_resp_yumi_o, busy_o;
  logic [LG-1:0]   grant_id_o;

  always #5 clk = ~clk;

  blackparrot_fpga_host_mmio_arb #(.num_req_p(N), .fifo_data_width_p(32), .addr_width_p(AW)) dut
    (.clk(clk), .reset(reset)
    ,.req_v_i(req_v_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_w_i(req_w_i)
    ,.req_yumi_o(req_yumi_o), .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_w_o(resp_w_o)
    ,.resp_ready_and_i(resp_ready_and_i)
    ,.fifo_v_o(fifo_v_o), .fifo_data_o(fifo_data_o), .fifo_ready_and_i(fifo_ready_and_i)
    ,.mmio_resp_v_i(mmio_resp_v_i), .mmio_resp_data_i(mmio_resp_data_i)
    ,.mmio_resp_yumi_o(mmio_resp_yumi_o), .grant_id_o(grant_id_o), .busy_o(busy_o)
    );

  typedef struct { logic [63:0] addr; logic [31:0] data; logic w; } txn_t;

  txn_t        cur [N];
  bit          pend [N];
  logic [31:0] host_q [$];
  logic [31:0] words [$];
  int          grants [$];
  int          arbs [$];

  int checks, fails;
  // stimulus knobs
  bit gen_en, gen_w_only, rdy_rand, rrdy_rand, push_data_forced;
  logic [N-1:0] gen_mask, rrdy_force;
  logic fifo_rdy_force;
  int gen_pct, push_delay_force;
  logic [31:0] push_data_force;
  // model
  logic [LG-1:0] last_m, owner;
  bit in_txn, expect_resp, resp_is_w, push_pend;
  int word_idx, cyc, push_at, arb_cyc, yumi_cyc, resp_cyc;
  int issued, done, abandoned, my_cnt;
  logic [31:0] push_data, last_rdata;
  logic [N-1:0] last_resp_v;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] oh(input logic [LG-1:0] i);
    return N'(1) << i;
  endfunction

  // Winner is the pending requester at the smallest cyclic distance past the last winner.
  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    int best, bd, d;
    best = -1; bd = N + 1;
    for (int i = 0; i < N; i++) begin
      d = (i - last - 1 + 2*N) % N;
      if (v[i] && d < bd) begin bd = d; best = i; end
    end
    return best;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic post(input int r, input logic [63:0] a, input logic [31:0] d, input logic w);
    cur[r].addr = a; cur[r].data = d; cur[r].w = w; pend[r] = 1'b1; issued++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (gen_en && gen_mask[i] && !pend[i] && $urandom_range(99) < gen_pct)
        post(i, {$urandom, $urandom}, $urandom, gen_w_only ? 1'b1 : 1'($urandom_range(1)));
      req_v_i[i]              = pend[i];
      req_w_i[i]              = cur[i].w;
      req_addr_i[i*AW +: AW]  = cur[i].addr;
      req_data_i[i*32 +: 32]  = cur[i].data;
    end
    fifo_ready_and_i = rdy_rand ? 1'($urandom_range(1)) : fifo_rdy_force;
    resp_ready_and_i = rrdy_rand ? N'($urandom) : rrdy_force;
    if (push_pend && cyc >= push_at) begin host_q.push_back(push_data); push_pend = 1'b0; end
    mmio_resp_v_i    = host_q.size() != 0;
    mmio_resp_data_i = mmio_resp_v_i ? host_q[0] : 32'h0;
  endtask

  task automatic sample();
    bit hs, exp_v, exp_my;
    if (reset) begin
      chk("rst_hs", 64'({fifo_v_o, req_yumi_o, resp_v_o, mmio_resp_yumi_o, resp_w_o, busy_o}), 64'd0);
      chk("rst_data", 64'({fifo_data_o, resp_data_o}), 64'd0);
      if (in_txn && expect_resp) abandoned++;
      in_txn = 1'b0; expect_resp = 1'b0; last_m = LG'(N-1);
      host_q.delete(); push_pend = 1'b0;
      return;
    end
    if (mmio_resp_yumi_o) my_cnt++;
    chk("busy", 64'(busy_o), 64'(in_txn));
    if (!in_txn) begin
      chk("idle_hs", 64'({fifo_v_o, req_yumi_o, resp_v_o, mmio_resp_yumi_o, resp_w_o}), 64'd0);
      chk("idle_data", 64'({fifo_data_o, resp_data_o}), 64'd0);
      if (|req_v_i) begin
        owner = LG'(rr_pick(int'(last_m), req_v_i));
        last_m = owner; in_txn = 1'b1; word_idx = 0; expect_resp = 1'b0;
        arb_cyc = cyc; grants.push_back(int'(owner)); arbs.push_back(cyc);
        if (!cur[owner].w) begin
          push_pend = 1'b1;
          push_at   = cyc + (push_delay_force >= 0 ? push_delay_force : int'($urandom_range(8)));
          push_data = push_data_forced ? push_data_force : $urandom;
        end
      end
      return;
    end
    chk("grant_id", 64'(grant_id_o), 64'(owner));
    chk("fifo_v", 64'(fifo_v_o), 64'(!expect_resp));
    if (!expect_resp) begin
      chk("fifo_data", 64'(fifo_data_o), 64'(word_idx == 0 ? cur[owner].addr[31:0] : cur[owner].data));
      hs = fifo_ready_and_i;
      chk("req_yumi", 64'(req_yumi_o), 64'((hs && word_idx == 1) ? oh(owner) : {N{1'b0}}));
      chk("resp_quiet", 64'({resp_v_o, mmio_resp_yumi_o, resp_w_o, resp_data_o}), 64'd0);
      if (hs) begin
        words.push_back(fifo_data_o);
        if (word_idx == 1) begin
          yumi_cyc = cyc; pend[owner] = 1'b0; expect_resp = 1'b1; resp_is_w = cur[owner].w;
        end
        word_idx++;
      end
    end else begin
      chk("req_yumi", 64'(req_yumi_o), 64'd0);
      exp_v  = resp_is_w || host_q.size() != 0;
      exp_my = !resp_is_w && host_q.size() != 0 && resp_ready_and_i[owner];
      chk("resp_v", 64'(resp_v_o), 64'(exp_v ? oh(owner) : {N{1'b0}}));
      chk("resp_w", 64'(resp_w_o), 64'(resp_is_w));
      chk("resp_data", 64'(resp_data_o), 64'(resp_is_w ? 32'h0 : (host_q.size() != 0 ? host_q[0] : 32'h0)));
      chk("mmio_yumi", 64'(mmio_resp_yumi_o), 64'(exp_my));
      if (exp_v && resp_ready_and_i[owner]) begin
        resp_cyc = cyc; last_rdata = resp_data_o; last_resp_v = resp_v_o;
        if (!resp_is_w) void'(host_q.pop_front());
        in_txn = 1'b0; expect_resp = 1'b0; done++;
      end
    end
  endtask

  task automatic step();
    drive();
    #1;
    sample();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  task automatic run_idle(input int maxc, input string tag);
    int n;
    n = 0;
    while ((in_txn || any_pend()) && n < maxc) begin step(); n++; end
    chk({tag, "_timeout"}, 64'(n >= maxc), 64'd0);
  endtask

  int c0, k;

  initial begin
    checks = 0; fails = 0; cyc = 0; issued = 0; done = 0; abandoned = 0; my_cnt = 0;
    gen_en = 0; gen_w_only = 0; gen_mask = '1; gen_pct = 30;
    rdy_rand = 0; fifo_rdy_force = 1'b1; rrdy_rand = 0; rrdy_force = '1;
    push_delay_force = -1; push_data_forced = 0; push_data_force = '0;
    in_txn = 0; expect_resp = 0; resp_is_w = 0; push_pend = 0; last_m = LG'(N-1); owner = '0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; cur[i] = '{addr: 64'h0, data: 32'h0, w: 1'b0}; end
    reset = 1'b1; req_v_i = '0; req_w_i = '0; req_addr_i = '0; req_data_i = '0;
    fifo_ready_and_i = 1'b0; resp_ready_and_i = '0; mmio_resp_v_i = 1'b0; mmio_resp_data_i = '0;
    @(negedge clk);
    do_reset();

    // single write from requester 0
    words.delete();
    post(0, 64'h0000_0000_0010_1000, 32'h41, 1'b1);
    run_idle(50, "wr0");
    chk("wr0_nwords", 64'(words.size()), 64'd2);
    chk("wr0_word0", 64'(words[0]), 64'h0010_1000);
    chk("wr0_word1", 64'(words[1]), 64'h41);
    chk("wr0_yumi_lat", 64'(yumi_cyc - arb_cyc), 64'd2);
    chk("wr0_resp_lat", 64'(resp_cyc - arb_cyc), 64'd3);

    // single read from requester 1, host answers 5 cycles after arbitration
    push_delay_force = 5; push_data_forced = 1; push_data_force = 32'hDEAD_BEEF;
    c0 = my_cnt;
    post(1, 64'h0000_0000_0020_0000, 32'h5555_0000, 1'b0);
    run_idle(50, "rd1");
    chk("rd1_data", 64'(last_rdata), 64'hDEAD_BEEF);
    chk("rd1_resp_v", 64'(last_resp_v), 64'(3'b010));
    chk("rd1_mmio_yumi_cnt", 64'(my_cnt - c0), 64'd1);

    // continuous writes from 0 and 1 after reset
    do_reset();
    grants.delete(); arbs.delete();
    gen_en = 1; gen_mask = 3'b011; gen_pct = 100; gen_w_only = 1;
    for (int i = 0; i < 24; i++) step();
    gen_en = 0; gen_w_only = 0;
    run_idle(50, "rr");
    chk("rr_g0", 64'(grants[0]), 64'd0);
    chk("rr_g1", 64'(grants[1]), 64'd1);
    chk("rr_g2", 64'(grants[2]), 64'd0);
    chk("rr_g3", 64'(grants[3]), 64'd1);
    chk("rr_period", 64'(arbs[1] - arbs[0]), 64'd4);

    // host FIFO backpressure in e_addr then e_data
    words.delete();
    fifo_rdy_force = 1'b0;
    post(2, 64'hABCD_0000_0030_0040, 32'h0BAD_F00D, 1'b1);
    step();
    chk("bp_arb", 64'(busy_o), 64'd1);
    for (int i = 0; i < 10; i++) step();
    chk("bp_addr_words", 64'(words.size()), 64'd0);
    fifo_rdy_force = 1'b1; step();
    fifo_rdy_force = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("bp_data_words", 64'(words.size()), 64'd1);
    chk("bp_no_yumi", 64'(pend[2]), 64'd1);
    fifo_rdy_force = 1'b1;
    run_idle(50, "bp");
    chk("bp_words", 64'(words.size()), 64'd2);

    // host read response arrives while still in e_addr
    push_delay_force = 1; push_data_force = 32'h1234;
    fifo_rdy_force = 1'b0;
    post(0, 64'h0000_0000_0000_0200, 32'h0, 1'b0);
    c0 = my_cnt;
    for (int i = 0; i < 5; i++) step();
    chk("early_untouched", 64'(my_cnt - c0), 64'd0);
    fifo_rdy_force = 1'b1;
    run_idle(50, "early");
    chk("early_data", 64'(last_rdata), 64'h1234);
    chk("early_resp_v", 64'(last_resp_v), 64'(3'b001));
    chk("early_cnt", 64'(my_cnt - c0), 64'd1);

    // reset while holding a read response the requester will not take
    push_delay_force = 2; push_data_force = 32'h7777_7777; rrdy_force = '0;
    post(1, 64'h0000_0000_0000_0300, 32'h0, 1'b0);
    k = 0;
    while (!(expect_resp && host_q.size() != 0) && k < 20) begin step(); k++; end
    chk("rst_rr_reach", 64'(k >= 20), 64'd0);
    step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    rrdy_force = '1; push_delay_force = -1; push_data_forced = 0;
    grants.delete();
    post(0, 64'h0000_0000_0000_0400, 32'h11, 1'b1);
    post(1, 64'h0000_0000_0000_0500, 32'h22, 1'b1);
    run_idle(50, "post_rst");
    chk("post_rst_g0", 64'(grants[0]), 64'd0);
    chk("post_rst_g1", 64'(grants[1]), 64'd1);

    // random traffic with random backpressure and occasional reset
    gen_en = 1; gen_mask = '1; gen_pct = 30; rdy_rand = 1; rrdy_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(299) == 0);
      step();
    end
    reset = 1'b0;
    gen_en = 0; rdy_rand = 0; fifo_rdy_force = 1'b1; rrdy_rand = 0; rrdy_force = '1;
    run_idle(300, "drain");
    chk("drain_count", 64'(done + abandoned), 64'(issued));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
